pipe_stage_skid: RTL

Parametrised, elastic pipeline stage register for the RV32 core: carries an arbitrary-width payload (decoded control + operands) between two pipeline stages with a valid/ready handshake and a two-entry skid buffer, replacing fixed enable/reset stage registers. Provides full throughput with no combinational ready path, synchronous flush for branch/jump squash, and optional performance counters. Intended between ID and EX first, then reused at IF/ID, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake with a two-entry skid buffer and sync flush.
// Optional stall/bubble/flush counters are built when PIPE_STAGE_SKID_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_main, w_main_nxt;
    logic [WIDTH-1:0] r_skid, w_skid_nxt;
    logic             w_in_fire, w_out_fire;

    // Handshake outputs decode only from the state flops.
    assign out_valid_o = (r_state != EMPTY);
    assign in_ready_o  = (r_state != FULL);
    assign out_data_o  = r_main;
    assign occupancy_o = r_state;

    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = in_data_i;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data_i;
                end else if (w_in_fire) begin
                    w_state_nxt = FULL;
                    w_skid_nxt  = in_data_i;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ONE;
                    w_main_nxt  = r_skid;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Squash overrides any handshake this cycle; arriving beat is dropped.
        if (flush_i) begin
            w_state_nxt = EMPTY;
            if (FLUSH_ZERO) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end
    end

`ifdef PIPE_STAGE_SKID_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!out_valid_o && out_ready_i && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (flush_i && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule
